// File: rtl/core_io_axil_pkg.sv
// Shared definitions for the core I/O AXI4-Lite master.
//   state_t      : transaction FSM states
//   rsp_err_t    : completion status codes returned on RSP_ERR
//   REG_*        : byte offsets of the peripheral registers inside a channel window
//   STAT_*       : bit positions inside the peripheral status register
package core_io_axil_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ST_AR,
        ST_R,
        RD_AR,
        RD_R,
        WR_AWW,
        WR_B,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK   = 2'b00,
        ERR_SLV  = 2'b01,
        ERR_TMO  = 2'b10,
        ERR_NRDY = 2'b11
    } rsp_err_t;

    localparam int REG_RX   = 0;
    localparam int REG_TX   = 4;
    localparam int REG_STAT = 8;

    localparam int STAT_RX_VALID = 0;
    localparam int STAT_TX_FULL  = 3;

endpackage

// File: rtl/core_io_axil_if.sv
// AXI4-Lite bus between the core I/O master and the interconnect.
//   master : drives AR/AW/W channels and R/B ready
//   slave  : drives address/data ready and R/B responses
// Data buses are fixed at 32 bits; only the address width is parametrised.
interface core_io_axil_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] ARADDR;
    logic              ARVALID;
    logic              ARREADY;
    logic [31:0]       RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;
    logic [ADDR_W-1:0] AWADDR;
    logic              AWVALID;
    logic              AWREADY;
    logic [31:0]       WDATA;
    logic [3:0]        WSTRB;
    logic              WVALID;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;

    modport master (
        output ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        input  ARREADY, RDATA, RRESP, RVALID, AWREADY, WREADY, BRESP, BVALID
    );

    modport slave (
        input  ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        output ARREADY, RDATA, RRESP, RVALID, AWREADY, WREADY, BRESP, BVALID
    );
endinterface

// File: rtl/core_io_axil.sv
// AXI4-Lite I/O master serving the core's IN/OUT instructions against N_CH
// UART-Lite style peripherals. One request at a time: poll the channel status
// register until ready, then read RX (IN) or write TX (OUT), then pulse a
// one-cycle response.
// Ports:
//   CLK, RST_N              clock, asynchronous active-low reset
//   REQ_VALID/REQ_READY     request handshake; REQ_WRITE=1 for OUT, REQ_NB=1 for
//                           non-blocking, REQ_CH channel, REQ_WDATA OUT payload
//   RSP_VALID               one-cycle completion pulse with RSP_RDATA / RSP_ERR
//   BUSY                    high whenever a request is in flight
//   axi                     AXI4-Lite master port
module core_io_axil
    import core_io_axil_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int N_CH       = 2,
    parameter int CH_BASE    = 0,
    parameter int CH_STRIDE  = 16,
    parameter int POLL_LIMIT = 1024,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WRITE,
    input  logic              REQ_NB,
    input  logic [CH_W-1:0]   REQ_CH,
    input  logic [DATA_W-1:0] REQ_WDATA,
    output logic              RSP_VALID,
    output logic [31:0]       RSP_RDATA,
    output logic [1:0]        RSP_ERR,
    output logic              BUSY,
    core_io_axil_if.master    axi
);

    localparam int CNT_W = (POLL_LIMIT > 0) ? $clog2(POLL_LIMIT + 1) : 1;
    localparam logic [3:0] WSTRB_VAL = 4'((1 << (DATA_W / 8)) - 1);

    function automatic logic [ADDR_W-1:0] reg_addr(input logic [CH_W-1:0] ch, input int off);
        return ADDR_W'(CH_BASE + int'(ch) * CH_STRIDE + off);
    endfunction

    // Saturating increment so the poll counter can never wrap back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    state_t              state_q, state_d;
    logic                init_q;
    logic                wr_q, nb_q;
    logic [CH_W-1:0]     ch_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [CNT_W-1:0]    cnt_q, cnt_inc;
    logic                aw_done_q, w_done_q;
    logic [31:0]         rdata_q;
    rsp_err_t            err_q;

    logic req_fire, ch_ok, stat_ready, poll_timeout;
    logic aw_vld, w_vld, aw_fire, w_fire;

    // Only the status bits and the low DATA_W payload bits of RDATA matter.
    wire unused_rdata = &{1'b0, axi.RDATA};

    assign req_fire     = REQ_VALID && REQ_READY;
    assign ch_ok        = {1'b0, REQ_CH} < (CH_W + 1)'(N_CH);
    assign stat_ready   = wr_q ? !axi.RDATA[STAT_TX_FULL] : axi.RDATA[STAT_RX_VALID];
    assign cnt_inc      = sat_inc(cnt_q);
    assign poll_timeout = (POLL_LIMIT != 0) && (cnt_inc == CNT_W'(POLL_LIMIT));
    assign aw_vld       = (state_q == WR_AWW) && !aw_done_q;
    assign w_vld        = (state_q == WR_AWW) && !w_done_q;
    assign aw_fire      = aw_vld && axi.AWREADY;
    assign w_fire       = w_vld && axi.WREADY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_fire) state_d = ch_ok ? ST_AR : DONE;
            ST_AR:   if (axi.ARREADY) state_d = ST_R;
            ST_R: begin
                if (axi.RVALID) begin
                    if (axi.RRESP != 2'b00)  state_d = DONE;
                    else if (stat_ready)     state_d = wr_q ? WR_AWW : RD_AR;
                    else if (nb_q)           state_d = DONE;
                    else if (poll_timeout)   state_d = DONE;
                    else                     state_d = ST_AR;
                end
            end
            RD_AR:   if (axi.ARREADY) state_d = RD_R;
            RD_R:    if (axi.RVALID) state_d = DONE;
            // AW and W complete independently; leave once both have been taken.
            WR_AWW:  if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = WR_B;
            WR_B:    if (axi.BVALID) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        REQ_READY   = init_q && (state_q == IDLE);
        BUSY        = (state_q != IDLE);
        RSP_VALID   = (state_q == DONE);
        RSP_RDATA   = (state_q == DONE) ? rdata_q : '0;
        RSP_ERR     = (state_q == DONE) ? err_q : ERR_OK;
        axi.ARVALID = (state_q == ST_AR) || (state_q == RD_AR);
        axi.ARADDR  = '0;
        if (state_q == ST_AR)      axi.ARADDR = reg_addr(ch_q, REG_STAT);
        else if (state_q == RD_AR) axi.ARADDR = reg_addr(ch_q, REG_RX);
        axi.RREADY  = (state_q == ST_R) || (state_q == RD_R);
        axi.AWVALID = aw_vld;
        axi.AWADDR  = aw_vld ? reg_addr(ch_q, REG_TX) : '0;
        axi.WVALID  = w_vld;
        axi.WDATA   = w_vld ? 32'(wdata_q) : '0;
        axi.WSTRB   = w_vld ? WSTRB_VAL : '0;
        axi.BREADY  = (state_q == WR_B);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            init_q    <= 1'b0;
            wr_q      <= 1'b0;
            nb_q      <= 1'b0;
            ch_q      <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= ERR_OK;
        end else begin
            init_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (req_fire) begin
                        wr_q      <= REQ_WRITE;
                        nb_q      <= REQ_NB;
                        ch_q      <= REQ_CH;
                        wdata_q   <= REQ_WDATA;
                        cnt_q     <= '0;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        rdata_q   <= '0;
                        err_q     <= ch_ok ? ERR_OK : ERR_SLV;
                    end
                end
                ST_R: begin
                    if (axi.RVALID) begin
                        if (axi.RRESP != 2'b00) begin
                            err_q <= ERR_SLV;
                        end else if (!stat_ready) begin
                            if (nb_q) begin
                                err_q <= ERR_NRDY;
                            end else begin
                                cnt_q <= cnt_inc;
                                if (poll_timeout) err_q <= ERR_TMO;
                            end
                        end
                    end
                end
                RD_R: begin
                    if (axi.RVALID) begin
                        if (axi.RRESP != 2'b00) err_q <= ERR_SLV;
                        else                    rdata_q <= 32'(axi.RDATA[DATA_W-1:0]);
                    end
                end
                WR_AWW: begin
                    if (aw_fire) aw_done_q <= 1'b1;
                    if (w_fire)  w_done_q  <= 1'b1;
                end
                WR_B: begin
                    if (axi.BVALID && (axi.BRESP != 2'b00)) err_q <= ERR_SLV;
                end
                default: ;
            endcase
        end
    end

endmodule
